// File: rtl/router_fifo.sv
// router_fifo: per-destination output buffer of the 1x3 router.
// Stores {header_tag, byte} entries and tracks the remaining bytes of the
// packet being read using the header's length field.
// Optional feature macro: ROUTER_FIFO_OVF_EN adds a sticky `overflow` output.
module router_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
`ifdef ROUTER_FIFO_OVF_EN
    output logic             overflow,
`endif
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Entry layout: bit WIDTH is the header tag, low WIDTH bits are data.
    logic [WIDTH:0]  mem [DEPTH];

    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [5:0]      pkt_cnt_q, pkt_cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;

    logic            do_write;
    logic            do_read;
    logic [WIDTH:0]  rd_entry;

    // Flags are decoded from the registered pointers only.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    end

    // Qualify requests against the pre-edge flags; soft_reset overrides both.
    always_comb begin
        do_write = write_enb && !full && !soft_reset;
        do_read  = read_enb && !empty && !soft_reset;
        rd_entry = mem[rd_ptr_q[AW-1:0]];
    end

    // Next-state for pointers, packet counter and read data.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pkt_cnt_d  = pkt_cnt_q;
        data_out_d = data_out_q;
        if (soft_reset) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            pkt_cnt_d  = '0;
            data_out_d = '0;
        end else begin
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_read) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                data_out_d = rd_entry[WIDTH-1:0];
                if (rd_entry[WIDTH]) begin
                    // Payload length plus the trailing parity byte.
                    pkt_cnt_d = rd_entry[7:2] + 6'd1;
                end else if (pkt_cnt_q != 6'd0) begin
                    pkt_cnt_d = pkt_cnt_q - 6'd1;
                end
            end else if (pkt_cnt_q == 6'd0) begin
                // Idle bus between packets.
                data_out_d = '0;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_cnt_q  <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
        end
    end

    assign data_out = data_out_q;

`ifdef ROUTER_FIFO_OVF_EN
    logic overflow_q;

    // Sticky record of any write attempted while full.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overflow_q <= 1'b0;
        end else if (soft_reset) begin
            overflow_q <= 1'b0;
        end else if (write_enb && full) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo.
module tb_router_fifo;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       soft_reset = 1'b0;
    logic       write_enb = 1'b0;
    logic       read_enb = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
`ifdef ROUTER_FIFO_OVF_EN
    logic       overflow;
`endif

    int checks = 0;
    int errors = 0;

    router_fifo #(
        .DEPTH(16),
        .WIDTH(8)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
`ifdef ROUTER_FIFO_OVF_EN
        .overflow   (overflow),
`endif
        .full       (full),
        .empty      (empty)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic hdr, input logic [7:0] d);
        write_enb = 1'b1;
        lfd_state = hdr;
        data_in   = d;
        tick();
        write_enb = 1'b0;
        lfd_state = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] exp);
        read_enb = 1'b1;
        tick();
        read_enb = 1'b0;
        check(tag, data_out, exp);
    endtask

    logic [7:0] pkt [5];
    logic [7:0] d;

    initial begin
        pkt[0] = 8'h0C; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h5A;

        // Reset state
        #12;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_dout", data_out, 0);
`ifdef ROUTER_FIFO_OVF_EN
        check("rst_ovf", overflow, 0);
`endif
        tick();
        resetn = 1'b1;
        tick();

        // Single packet: header length 3, three payload bytes, parity
        wr(1'b1, pkt[0]);
        check("empty_after_first_wr", empty, 0);
        for (int i = 1; i < 5; i++) wr(1'b0, pkt[i]);
        read_enb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("pkt_rd%0d", i), data_out, pkt[i]);
        end
        read_enb = 1'b0;
        tick();
        check("pkt_idle_dout", data_out, 0);
        check("pkt_empty", empty, 1);

        // Fill to DEPTH
        for (int i = 0; i < 16; i++) begin
            wr(1'b0, 8'hA0 + 8'(i));
            if (i == 14) check("full_at_15", full, 0);
        end
        check("full_at_16", full, 1);
        check("full_not_empty", empty, 0);
        wr(1'b0, 8'hFF);
        check("full_after_drop", full, 1);
`ifdef ROUTER_FIFO_OVF_EN
        check("ovf_set", overflow, 1);
`endif

        // Read and write together while full: read wins, write dropped
        write_enb = 1'b1;
        data_in   = 8'hEE;
        read_enb  = 1'b1;
        tick();
        write_enb = 1'b0;
        read_enb  = 1'b0;
        check("rw_full_dout", data_out, 8'hA0);
        check("rw_full_full", full, 0);
`ifdef ROUTER_FIFO_OVF_EN
        check("rw_full_ovf", overflow, 1);
`endif
        read_enb = 1'b1;
        for (int i = 1; i < 16; i++) begin
            tick();
            check($sformatf("drain%0d", i), data_out, 8'hA0 + 8'(i));
        end
        read_enb = 1'b0;
        check("drain_empty", empty, 1);
        check("drain_not_full", full, 0);

        // Interleaved pairs across the pointer wrap
        for (int i = 0; i < 40; i++) begin
            d = 8'(i * 7 + 3);
            wr(1'b0, d);
            check($sformatf("wrap_full%0d", i), full, 0);
            rd($sformatf("wrap_rd%0d", i), d);
        end
        check("wrap_empty", empty, 1);

        // Soft reset with a concurrent read
        for (int i = 0; i < 6; i++) wr(1'b0, 8'h60 + 8'(i));
        rd("sr_pre_rd", 8'h60);
        soft_reset = 1'b1;
        read_enb   = 1'b1;
        tick();
        soft_reset = 1'b0;
        read_enb   = 1'b0;
        check("sr_empty", empty, 1);
        check("sr_dout", data_out, 0);
`ifdef ROUTER_FIFO_OVF_EN
        check("sr_ovf", overflow, 0);
`endif

        // Asynchronous reset mid-packet
        wr(1'b1, 8'h08);
        wr(1'b0, 8'h44);
        rd("ar_hdr", 8'h08);
        #3;
        resetn = 1'b0;
        #1;
        check("ar_empty", empty, 1);
        check("ar_full", full, 0);
        check("ar_dout", data_out, 0);
        #2;
        resetn = 1'b1;
        tick();

        // Next header reloads the counter
        wr(1'b1, 8'h04);
        wr(1'b0, 8'h77);
        wr(1'b0, 8'h12);
        read_enb = 1'b1;
        tick();
        check("re_hdr", data_out, 8'h04);
        tick();
        check("re_pay", data_out, 8'h77);
        tick();
        check("re_par", data_out, 8'h12);
        read_enb = 1'b0;
        tick();
        check("re_idle", data_out, 0);
        check("re_empty", empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
# router_fifo

Per-destination output buffer of the 1x3 router: one instance per output port, written by the address synchronizer's one-hot write enable and read by the destination client. Stores header, payload and parity bytes, tags each stored byte with a header marker, and uses the header's length field to track how many bytes of the current packet remain to be read. Its `full` and `empty` flags feed back to the synchronizer, which uses them for the fifo-full selection, the valid-out signals and the soft-reset timeout.

## Interface
- `DEPTH`, 16, number of entries; power of two, at least 4.
- `WIDTH`, 8, data byte width; stored entry width is `WIDTH+1`.

- `clock`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous active-low reset.
- `soft_reset`  in  1  synchronous flush from the synchronizer timeout.
- `write_enb`  in  1  this port's bit of the synchronizer write enable.
- `read_enb`  in  1  read request from the destination client.
- `lfd_state`  in  1  high while the header byte is being written.
- `data_in`  in  WIDTH  byte to store.
- `data_out`  out  WIDTH  registered read data.
- `full`  out  1  all DEPTH entries occupied.
- `empty`  out  1  no entries occupied.
- `overflow`  out  1  sticky dropped-write flag; present only with `ROUTER_FIFO_OVF_EN`.

## Operation
- Storage: DEPTH x (WIDTH+1) array. Bit WIDTH holds the header tag (the `lfd_state` value at write time).
- Pointers: `wr_ptr` and `rd_ptr` are each log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH. Indexing uses the low log2(DEPTH) bits.
  - `empty` = (`wr_ptr` == `rd_ptr`).
  - `full` = MSBs differ and low bits are equal.
  - Both flags are combinational from the registered pointers.
- Write: when `write_enb` is high and `full` is low, store {`lfd_state`, `data_in`} at `wr_ptr` and increment `wr_ptr`. A write while `full` is dropped.
- Read: when `read_enb` is high and `empty` is low, load `data_out` with the WIDTH data bits at `rd_ptr` and increment `rd_ptr`. A read while `empty` leaves `data_out` unchanged.
- Packet counter `pkt_cnt` (6 bits):
  - On a read of a header-tagged entry: `pkt_cnt` <= data[7:2] + 1, i.e. payload length plus the parity byte.
  - On a read of a non-header entry with `pkt_cnt` != 0: `pkt_cnt` decrements by 1.
  - A cycle with no read and `pkt_cnt` == 0: `data_out` <= 0 (idle bus).
- Simultaneous read and write:
  - Both are evaluated against the pre-edge flags.
  - When full, the read succeeds and the write is dropped.
  - When empty, the write succeeds and the read is ignored.
  - Otherwise both proceed and the occupancy count is unchanged.
- `soft_reset`:
  - Clears both pointers, `pkt_cnt` and `data_out` to 0.
  - Has priority over any read or write in the same cycle.
  - Memory contents are don't-care afterwards.

## Timing
- Reset (`resetn` low, asynchronous): pointers = 0, `pkt_cnt` = 0, `data_out` = 0, `empty` = 1, `full` = 0, `overflow` = 0.
- Write-to-flag latency: `empty` deasserts in the cycle after the first write edge.
- Read latency: `data_out` is valid one clock after the edge at which `read_enb` is sampled high.
- `full` asserts after the DEPTH-th net write. It deasserts the cycle after one read.
- Pointer wrap: after 2*DEPTH operations the pointers return to 0. Flags stay correct across the wrap.
- `resetn` asserted mid-packet aborts immediately. The next header read reloads `pkt_cnt`.

## Configuration
- `ROUTER_FIFO_OVF_EN` defined:
  - Adds the `overflow` output.
  - `overflow` sets on any cycle with `write_enb` high and `full` high.
  - It stays high until `resetn` or `soft_reset`.
- `ROUTER_FIFO_OVF_EN` undefined: port and logic are absent, and writes while full are dropped silently.

## Test plan
- Reset, then write header 0x0C (length 3, tag 1), bytes 0x11, 0x22, 0x33 and parity 0x5A; read 5 times -> `data_out` = 0x0C, 0x11, 0x22, 0x33, 0x5A on successive cycles, then 0x00 the cycle after the last read; `empty` = 1.
- Write 16 bytes with no reads -> `full` = 1 after the 16th; a 17th write is dropped; reading 16 times returns the original order, and `empty` = 1 after the 16th read.
- With the FIFO full, assert read and write together -> one byte out, new byte dropped, `full` = 0; with `ROUTER_FIFO_OVF_EN`, `overflow` = 1.
- Run 40 interleaved write/read pairs to cross the pointer wrap -> data order preserved, `full` never asserts, `empty` = 1 at the end.
- Load 6 bytes, pulse `soft_reset` together with `read_enb` -> next cycle `empty` = 1, `data_out` = 0x00, and `overflow` (if present) = 0.
- Assert `resetn` low asynchronously between clock edges mid-packet -> outputs go to reset values without waiting for a clock edge.
